// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types, widths and parameter defaults for the 4:1 word aligner
//
// Contents:
//   WORD_W             parallel word width delivered by the ISERDESE2 (DDR, width 4)
//   DEF_*              default values for the aligner parameters
//   align_state_t      alignment FSM state encoding
//   sat_inc4()         4-bit increment that sticks at 15
package serdes_pkg;

    localparam int WORD_W = 4;

    localparam logic [WORD_W-1:0] DEF_TRAIN_PATTERN = 4'b1100;
    localparam int DEF_SETTLE_CYCLES = 3;
    localparam int DEF_MATCH_COUNT   = 16;
    localparam int DEF_MISS_LIMIT    = 4;
    localparam int DEF_MAX_SLIPS     = 8;

    typedef enum logic [2:0] {
        ST_CHECK  = 3'd0,
        ST_SLIP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } align_state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/align_lock_mon.sv
// rtl/align_lock_mon.sv - training-word compare and match/miss run counters for the aligner FSM
//
// Ports:
//   c           in   word-rate clock
//   rst         in   asynchronous active-high reset
//   din         in   current parallel word from the ISERDES
//   train       in   transmitter is sending the training word
//   check_en    in   FSM is in CHECK: count consecutive matches
//   lock_en     in   FSM is in LOCKED: count consecutive misses
//   clr         in   clear both counters (FSM transition or realign)
//   mismatch    out  din differs from the training word (combinational)
//   match_done  out  match run has reached MATCH_COUNT
//   miss_limit  out  miss run has reached MISS_LIMIT
module align_lock_mon
    import serdes_pkg::*;
#(
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int                MISS_LIMIT    = DEF_MISS_LIMIT
) (
    input  logic              c,
    input  logic              rst,
    input  logic [WORD_W-1:0] din,
    input  logic              train,
    input  logic              check_en,
    input  logic              lock_en,
    input  logic              clr,
    output logic              mismatch,
    output logic              match_done,
    output logic              miss_limit
);

    localparam logic [7:0] MATCH_TGT = 8'(MATCH_COUNT);
    localparam logic [3:0] MISS_TGT  = 4'(MISS_LIMIT);

    logic [7:0] match_cnt;
    logic [3:0] miss_cnt;

    assign mismatch   = (din != TRAIN_PATTERN);
    // Strobes come from the registered counts, so the FSM acts one cycle
    // after the deciding word has been counted.
    assign match_done = (match_cnt == MATCH_TGT);
    assign miss_limit = (miss_cnt == MISS_TGT);

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else if (clr) begin
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            // With train low both counters are frozen.
            if (check_en && train) begin
                if (mismatch) begin
                    match_cnt <= '0;
                end else if (!match_done) begin
                    match_cnt <= match_cnt + 8'd1;
                end
            end
            if (lock_en && train) begin
                if (!mismatch) begin
                    miss_cnt <= '0;
                end else if (!miss_limit) begin
                    miss_cnt <= miss_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/iserdes_4x_align.sv
// rtl/iserdes_4x_align.sv - ISERDESE2 4:1 word aligner: bitslips until the training word locks, re-aligns on loss
//
// Optional feature macro: ISERDES_ALIGN_STATS_EN (enables the err_cnt mismatch counter).
//
// Ports:
//   c        in   word-rate clock (ISERDES CLKDIV)
//   rst      in   asynchronous active-high reset
//   din      in   [3:0] parallel word, din[0] = first bit received
//   train    in   transmitter is sending TRAIN_PATTERN
//   realign  in   one-cycle request to restart alignment
//   bitslip  out  one-cycle BITSLIP pulse to the ISERDESE2
//   dout     out  [3:0] din registered
//   dvalid   out  dout valid (locked and not training)
//   locked   out  alignment achieved
//   fail     out  slip budget exhausted without lock
//   slips    out  [3:0] slips since reset/realign, saturating at 15
//   err_cnt  out  [15:0] LOCKED-state training mismatches (zero unless stats enabled)
module iserdes_4x_align
    import serdes_pkg::*;
#(
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int                MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int                MISS_LIMIT    = DEF_MISS_LIMIT,
    parameter int                MAX_SLIPS     = DEF_MAX_SLIPS
) (
    input  logic              c,
    input  logic              rst,
    input  logic [WORD_W-1:0] din,
    input  logic              train,
    input  logic              realign,
    output logic              bitslip,
    output logic [WORD_W-1:0] dout,
    output logic              dvalid,
    output logic              locked,
    output logic              fail,
    output logic [3:0]        slips,
    output logic [15:0]       err_cnt
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);

    align_state_t state, state_next;
    logic [7:0]   settle_cnt;
    logic         mismatch;
    logic         match_done;
    logic         miss_limit;
    logic         mon_clr;

    // Every state change restarts the run counters; this covers the
    // SETTLE->CHECK restart and the lock-loss clear in one place.
    assign mon_clr = realign || (state_next != state);

    align_lock_mon #(
        .TRAIN_PATTERN(TRAIN_PATTERN),
        .MATCH_COUNT  (MATCH_COUNT),
        .MISS_LIMIT   (MISS_LIMIT)
    ) u_lock_mon (
        .c         (c),
        .rst       (rst),
        .din       (din),
        .train     (train),
        .check_en  (state == ST_CHECK),
        .lock_en   (state == ST_LOCKED),
        .clr       (mon_clr),
        .mismatch  (mismatch),
        .match_done(match_done),
        .miss_limit(miss_limit)
    );

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state <= ST_CHECK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CHECK: begin
                if (match_done) begin
                    state_next = ST_LOCKED;
                end else if (train && mismatch) begin
                    state_next = (slips >= SLIP_MAX) ? ST_FAIL : ST_SLIP;
                end
            end
            ST_SLIP:   state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt >= SETTLE_LAST) begin
                    state_next = ST_CHECK;
                end
            end
            ST_LOCKED: begin
                if (miss_limit) begin
                    state_next = ST_SLIP;
                end
            end
            ST_FAIL:   state_next = ST_FAIL;
            default:   state_next = ST_CHECK;
        endcase
        // realign wins over any lock-loss or FAIL decision made this cycle.
        if (realign) begin
            state_next = ST_CHECK;
        end
    end

    always_comb begin
        bitslip = (state == ST_SLIP);
        locked  = (state == ST_LOCKED);
        fail    = (state == ST_FAIL);
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dvalid     <= 1'b0;
            settle_cnt <= '0;
            slips      <= '0;
        end else begin
            dout   <= din;
            dvalid <= (state == ST_LOCKED) && !train;

            // Counts cycles spent in SETTLE; zero on entry.
            if ((state == ST_SETTLE) && (state_next == ST_SETTLE)) begin
                settle_cnt <= settle_cnt + 8'd1;
            end else begin
                settle_cnt <= '0;
            end

            // A lock loss starts a fresh slip budget; the SLIP state that
            // follows then counts itself.
            if (realign) begin
                slips <= '0;
            end else if ((state == ST_LOCKED) && (state_next == ST_SLIP)) begin
                slips <= '0;
            end else if (state == ST_SLIP) begin
                slips <= sat_inc4(slips);
            end
        end
    end

`ifdef ISERDES_ALIGN_STATS_EN
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (realign) begin
            err_cnt <= '0;
        end else if ((state == ST_LOCKED) && train && mismatch && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_iserdes_4x_align.sv
// tb/tb_iserdes_4x_align.sv - self-checking bench for iserdes_4x_align with a skewed ISERDES word model
module tb_iserdes_4x_align;

    localparam logic [3:0] PAT    = 4'b1100;
    localparam int         SETTLE = 3;
    localparam int         MATCHN = 16;
    localparam int         MAXS   = 8;
`ifdef ISERDES_ALIGN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  din;
    logic        train;
    logic        realign;
    logic        bitslip;
    logic [3:0]  dout;
    logic        dvalid;
    logic        locked;
    logic        fail;
    logic [3:0]  slips;
    logic [15:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // ISERDES model state: skew = bit offset of the word boundary,
    // mode 0 = skewed training stream, 1 = fixed_word, 2 = random words.
    int         skew;
    int         mode;
    int         slip_pulses;
    int         cyc;
    logic [3:0] fixed_word;
    logic [3:0] prev_din;

    always #5 clk = ~clk;

    iserdes_4x_align dut (
        .c      (clk),
        .rst    (rst),
        .din    (din),
        .train  (train),
        .realign(realign),
        .bitslip(bitslip),
        .dout   (dout),
        .dvalid (dvalid),
        .locked (locked),
        .fail   (fail),
        .slips  (slips),
        .err_cnt(err_cnt)
    );

    function automatic logic [3:0] rot_word(input int s);
        logic [7:0] two;
        logic [7:0] sh;
        two = {PAT, PAT};
        sh  = two >> s;
        return sh[3:0];
    endfunction

    // One word-clock step: observe at the falling edge, apply the
    // ISERDES response to any BITSLIP, then present the next word.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bitslip === 1'b1) begin
            slip_pulses++;
            skew = (skew + 3) % 4;
        end
        prev_din = din;
        case (mode)
            0:       din = rot_word(skew);
            1:       din = fixed_word;
            default: din = 4'($urandom);
        endcase
    endtask

    task automatic do_reset(input int s, input int m);
        rst     = 1'b1;
        realign = 1'b0;
        train   = 1'b1;
        skew    = s;
        mode    = m;
        tick();
        tick();
        rst         = 1'b0;
        cyc         = 0;
        slip_pulses = 0;
    endtask

    task automatic wait_lock(input int budget, output int at);
        while (locked !== 1'b1 && cyc < budget) tick();
        at = (locked === 1'b1) ? cyc : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; realign = 1'b0; train = 1'b1;
        mode = 1; fixed_word = 4'b1010; skew = 0;
        tick();
        tick();
        vectors++; if (bitslip !== 1'b0) begin miscompares++; $display("FAIL reset_bitslip: got %b want 0", bitslip); end
        vectors++; if (dout !== 4'h0) begin miscompares++; $display("FAIL reset_dout: got %h want 0", dout); end
        vectors++; if (dvalid !== 1'b0) begin miscompares++; $display("FAIL reset_dvalid: got %b want 0", dvalid); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked); end
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL reset_fail: got %b want 0", fail); end
        vectors++; if (slips !== 4'h0) begin miscompares++; $display("FAIL reset_slips: got %0d want 0", slips); end
        vectors++; if (err_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    endtask

    // Each misaligned word costs one compare, one slip and the settle wait;
    // lock then needs MATCHN matching words plus the cycle that enters LOCKED.
    task automatic test_align(input int s);
        int at;
        int want;
        do_reset(s, 0);
        want = s * (SETTLE + 2) + MATCHN + 1;
        wait_lock(400, at);
        vectors++; if (at != want) begin miscompares++; $display("FAIL align_time skew=%0d: locked at cycle %0d want %0d", s, at, want); end
        vectors++; if (slip_pulses != s) begin miscompares++; $display("FAIL align_pulses skew=%0d: got %0d want %0d", s, slip_pulses, s); end
        vectors++; if (slips !== 4'(s)) begin miscompares++; $display("FAIL align_slips skew=%0d: got %0d want %0d", s, slips, s); end
        vectors++; if (din !== PAT) begin miscompares++; $display("FAIL align_model skew=%0d: din %b want %b", s, din, PAT); end
    endtask

    task automatic test_random_skew();
        for (int i = 0; i < 4; i++) test_align(int'($urandom_range(0, 3)));
    endtask

    task automatic test_lock_loss();
        int at;
        do_reset(0, 0);
        wait_lock(400, at);
        vectors++; if (at < 0) begin miscompares++; $display("FAIL loss_prelock: no lock, got %0d", at); end
        fixed_word = 4'b0011;
        mode = 1; tick();
        tick(); tick();
        mode = 0; tick();
        tick();
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL loss_three_misses: locked %b want 1", locked); end
        mode = 1; tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL loss_miss%0d: locked %b want 1", i + 1, locked); end
        end
        tick();
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL loss_miss4: locked %b want 1", locked); end
        tick();
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL loss_drop: locked %b want 0", locked); end
        vectors++; if (bitslip !== 1'b1) begin miscompares++; $display("FAIL loss_bitslip: got %b want 1", bitslip); end
        vectors++; if (slips !== 4'h0) begin miscompares++; $display("FAIL loss_slips: got %0d want 0", slips); end
    endtask

    task automatic test_fail_realign();
        int want;
        fixed_word = 4'b0000;
        do_reset(0, 1);
        want = MAXS * (SETTLE + 2) + 1;
        while (fail !== 1'b1 && cyc < 400) tick();
        vectors++; if (cyc != want || fail !== 1'b1) begin miscompares++; $display("FAIL fail_time: fail=%b at cycle %0d want 1 at %0d", fail, cyc, want); end
        vectors++; if (slip_pulses != MAXS) begin miscompares++; $display("FAIL fail_pulses: got %0d want %0d", slip_pulses, MAXS); end
        vectors++; if (slips !== 4'(MAXS)) begin miscompares++; $display("FAIL fail_slips: got %0d want %0d", slips, MAXS); end
        repeat (20) tick();
        vectors++; if (slip_pulses != MAXS || fail !== 1'b1) begin miscompares++; $display("FAIL fail_hold: pulses %0d fail %b want %0d and 1", slip_pulses, fail, MAXS); end
        realign = 1'b1;
        tick();
        realign = 1'b0;
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL realign_fail: got %b want 0", fail); end
        vectors++; if (slips !== 4'h0) begin miscompares++; $display("FAIL realign_slips: got %0d want 0", slips); end
        vectors++; if (bitslip !== 1'b0 || locked !== 1'b0) begin miscompares++; $display("FAIL realign_state: bitslip %b locked %b want 0 0", bitslip, locked); end
        tick();
        vectors++; if (bitslip !== 1'b1) begin miscompares++; $display("FAIL realign_check: bitslip %b want 1 after compare", bitslip); end
    endtask

    task automatic test_datapath();
        int at;
        do_reset(0, 0);
        wait_lock(400, at);
        train = 1'b0;
        mode  = 2;
        for (int i = 0; i < 40; i++) begin
            tick();
            vectors++; if (dout !== prev_din) begin miscompares++; $display("FAIL dp_dout[%0d]: got %h want %h", i, dout, prev_din); end
            vectors++; if (dvalid !== 1'b1) begin miscompares++; $display("FAIL dp_dvalid[%0d]: got %b want 1", i, dvalid); end
            vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL dp_locked[%0d]: got %b want 1", i, locked); end
        end
        train = 1'b1;
        mode  = 0;
        tick();
        vectors++; if (dvalid !== 1'b0) begin miscompares++; $display("FAIL dp_train_dvalid: got %b want 0", dvalid); end
    endtask

    task automatic test_stats_and_reset();
        int         at;
        int         bad;
        logic [6:0] seq;
        do_reset(0, 0);
        wait_lock(400, at);
        fixed_word = 4'b0110;
        seq = 7'b0110111;
        bad = 0;
        for (int k = 0; k < 7; k++) begin
            mode = seq[k] ? 1 : 0;
            if (seq[k]) bad++;
            tick();
        end
        mode = 0; tick();
        vectors++; if (err_cnt !== (STATS ? 16'(bad) : 16'h0)) begin miscompares++; $display("FAIL stats_count: got %0d want %0d", err_cnt, STATS ? bad : 0); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL stats_locked: got %b want 1", locked); end
        mode = 1;
        repeat (4) begin bad++; tick(); end
        mode = 0; tick();
        tick();
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL stats_loss: locked %b want 0", locked); end
        vectors++; if (err_cnt !== (STATS ? 16'(bad) : 16'h0)) begin miscompares++; $display("FAIL stats_keep: got %0d want %0d", err_cnt, STATS ? bad : 0); end
        realign = 1'b1;
        tick();
        realign = 1'b0;
        vectors++; if (err_cnt !== 16'h0) begin miscompares++; $display("FAIL stats_realign: got %0d want 0", err_cnt); end

        do_reset(2, 0);
        while (slip_pulses == 0 && cyc < 50) tick();
        tick();
        vectors++; if (slips !== 4'h1) begin miscompares++; $display("FAIL settle_pre_slips: got %0d want 1", slips); end
        rst = 1'b1;
        #1;
        vectors++; if (bitslip !== 1'b0 || locked !== 1'b0 || fail !== 1'b0 || dvalid !== 1'b0) begin miscompares++; $display("FAIL async_flags: bitslip %b locked %b fail %b dvalid %b want 0", bitslip, locked, fail, dvalid); end
        vectors++; if (dout !== 4'h0) begin miscompares++; $display("FAIL async_dout: got %h want 0", dout); end
        vectors++; if (slips !== 4'h0) begin miscompares++; $display("FAIL async_slips: got %0d want 0", slips); end
        vectors++; if (err_cnt !== 16'h0) begin miscompares++; $display("FAIL async_err_cnt: got %0d want 0", err_cnt); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; realign = 1'b0; train = 1'b0; din = 4'h0;
        skew = 0; mode = 0; slip_pulses = 0; cyc = 0;
        fixed_word = 4'h0; prev_din = 4'h0;
        test_reset();
        test_align(0);
        test_align(1);
        test_random_skew();
        test_lock_loss();
        test_fail_realign();
        test_datapath();
        test_stats_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
